// File: rtl/booth_mul_arbiter_if.sv
// Client and multiplier signal bundle for booth_mul_arbiter.
// slave = arbiter side, master = clients plus BoothMul side.
interface booth_mul_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   done;
   logic [2*W-1:0]    res;
   logic              err;
   logic              busy;
   logic              mul_start;
   logic [W-1:0]      mul_a;
   logic [W-1:0]      mul_b;
   logic [2*W-1:0]    mul_y;
   logic              mul_valid;

   modport slave (
      input  req, req_a, req_b, mul_y, mul_valid,
      output ack, done, res, err, busy, mul_start, mul_a, mul_b
   );

   modport master (
      output req, req_a, req_b, mul_y, mul_valid,
      input  ack, done, res, err, busy, mul_start, mul_a, mul_b
   );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one sequential BoothMul among NREQ clients:
// IDLE -> ISSUE -> WAIT (valid or timeout) -> RESP, all outputs registered.
module booth_mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   booth_mul_arbiter_if.slave    bus
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_last;
   logic [IW-1:0]     r_gnt;
   logic [CW-1:0]     r_cnt;
   logic [NREQ-1:0]   r_ack;
   logic [NREQ-1:0]   r_done;
   logic [2*W-1:0]    r_res;
   logic              r_err;
   logic              r_busy;
   logic              r_mul_start;
   logic [W-1:0]      r_mul_a;
   logic [W-1:0]      r_mul_b;

   logic [IW-1:0]     w_gnt;
   logic              w_any;
   logic [IW:0]       w_sum;
   logic [IW-1:0]     w_sel;
   logic [NREQ-1:0]   w_gnt_oh;
   logic [NREQ-1:0]   w_done_oh;
   logic [W-1:0]      w_a;
   logic [W-1:0]      w_b;
   logic              w_timeout;

   // Search starts one past the last winner so every client gets a turn.
   always_comb begin
      w_gnt = '0;
      w_any = 1'b0;
      w_sum = '0;
      w_sel = '0;
      for (int i = 1; i <= NREQ; i++) begin
         w_sum = {1'b0, r_last} + (IW+1)'(i);
         if (w_sum >= (IW+1)'(NREQ)) begin
            w_sum = w_sum - (IW+1)'(NREQ);
         end
         w_sel = w_sum[IW-1:0];
         if (!w_any && bus.req[w_sel]) begin
            w_any = 1'b1;
            w_gnt = w_sel;
         end
      end
   end

   always_comb begin
      w_gnt_oh  = '0;
      w_done_oh = '0;
      w_a       = '0;
      w_b       = '0;
      w_gnt_oh[w_gnt]  = 1'b1;
      w_done_oh[r_gnt] = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         if (w_gnt == IW'(k)) begin
            w_a = bus.req_a[k*W +: W];
            w_b = bus.req_b[k*W +: W];
         end
      end
   end

   assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_last      <= IW'(NREQ - 1);
         r_gnt       <= '0;
         r_cnt       <= '0;
         r_ack       <= '0;
         r_done      <= '0;
         r_res       <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_mul_start <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
      end else begin
         r_ack       <= '0;
         r_done      <= '0;
         r_mul_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt       <= w_gnt;
                  r_mul_a     <= w_a;
                  r_mul_b     <= w_b;
                  r_ack       <= w_gnt_oh;
                  r_mul_start <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               // A late valid on the timeout cycle still returns the real product.
               if (bus.mul_valid) begin
                  r_res   <= bus.mul_y;
                  r_err   <= 1'b0;
                  r_done  <= w_done_oh;
                  r_state <= S_RESP;
               end else if (w_timeout) begin
                  r_res   <= '0;
                  r_err   <= 1'b1;
                  r_done  <= w_done_oh;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               r_res   <= '0;
               r_err   <= 1'b0;
               r_last  <= r_gnt;
               r_mul_a <= '0;
               r_mul_b <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ack       = r_ack;
   assign bus.done      = r_done;
   assign bus.res       = r_res;
   assign bus.err       = r_err;
   assign bus.busy      = r_busy;
   assign bus.mul_start = r_mul_start;
   assign bus.mul_a     = r_mul_a;
   assign bus.mul_b     = r_mul_b;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a small fixed-latency multiplier model.
module tb_booth_mul_arbiter;
   localparam int NREQ    = 4;
   localparam int W       = 8;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   booth_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   booth_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int n_ack  = 0;
   int n_done = 0;
   int n_start = 0;

   // Multiplier model: valid one cycle, four posedges after start.
   bit             never_valid = 1'b0;
   bit             force_valid = 1'b0;
   logic [2*W-1:0] m_prod;
   logic           m_valid;
   int             m_cnt;

   assign bus.mul_valid = m_valid | force_valid;
   assign bus.mul_y     = force_valid ? 16'h5A5A : m_prod;

   always @(posedge clk) begin
      if (!rst) begin
         m_cnt   <= 0;
         m_valid <= 1'b0;
         m_prod  <= '0;
      end else begin
         m_valid <= 1'b0;
         if (bus.mul_start) begin
            m_cnt  <= 3;
            m_prod <= $signed(bus.mul_a) * $signed(bus.mul_b);
         end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !never_valid) m_valid <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.ack != '0) n_ack++;
      if (bus.done != '0) n_done++;
      if (bus.mul_start) n_start++;
      if ((bus.ack | bus.done) != '0) chk("ack_done_disjoint", 32'(bus.ack & bus.done), 32'd0);
   end

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ack();
      int c;
      c = 0;
      while (bus.ack == '0 && c < 50) begin tick(1); c++; end
   endtask

   task automatic wait_done(output int c);
      c = 0;
      while (bus.done == '0 && c < 200) begin tick(1); c++; end
   endtask

   // One client transaction; lat is ack-cycle to done-cycle distance.
   task automatic serve(input string tag, input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_res, input logic exp_err, output int lat);
      int c;
      bus.req_a[i*W +: W] = a;
      bus.req_b[i*W +: W] = b;
      bus.req[i] = 1'b1;
      wait_ack();
      chk({tag, "_ack"}, 32'(bus.ack), 32'(oh(i)));
      bus.req[i] = 1'b0;
      bus.req_a[i*W +: W] = ~a;
      bus.req_b[i*W +: W] = ~b;
      tick(1);
      chk({tag, "_hold_a"}, 32'(bus.mul_a), 32'(a));
      chk({tag, "_hold_b"}, 32'(bus.mul_b), 32'(b));
      wait_done(c);
      lat = c + 1;
      chk({tag, "_done"}, 32'(bus.done), 32'(oh(i)));
      chk({tag, "_res"}, 32'(bus.res), 32'(exp_res));
      chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
      tick(1);
      chk({tag, "_res_clr"}, 32'(bus.res), 32'd0);
      chk({tag, "_err_clr"}, 32'(bus.err), 32'd0);
      chk({tag, "_idle"}, {30'd0, bus.busy, bus.mul_a != '0}, 32'd0);
   endtask

   logic [W-1:0]   ta [4] = '{8'd3, 8'hFE, 8'd100, 8'h80};
   logic [W-1:0]   tb [4] = '{8'd5, 8'd9, 8'd100, 8'd127};
   logic [2*W-1:0] tp [4] = '{16'h000F, 16'hFFEE, 16'h2710, 16'hC080};

   initial begin
      int lat;
      int c;
      int d0;
      bus.req   = '0;
      bus.req_a = '0;
      bus.req_b = '0;

      tick(3);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ack_done", {bus.ack, bus.done}, 32'd0);
      chk("rst_res_err", {bus.res, 15'd0, bus.err}, 32'd0);
      chk("rst_mul", {7'd0, bus.mul_start, bus.mul_a, bus.mul_b}, 32'd0);
      rst = 1'b1;
      tick(2);

      // All four requesting: grants follow 0,1,2,3 from the reset pointer.
      for (int k = 0; k < 4; k++) begin
         bus.req_a[k*W +: W] = ta[k];
         bus.req_b[k*W +: W] = tb[k];
      end
      bus.req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_ack();
         chk("rr_ack", 32'(bus.ack), 32'(oh(k)));
         bus.req[k] = 1'b0;
         wait_done(c);
         chk("rr_done", 32'(bus.done), 32'(oh(k)));
         chk("rr_res", 32'(bus.res), 32'(tp[k]));
      end

      bus.req_a[0*W +: W] = 8'd7;
      bus.req_b[0*W +: W] = 8'hFF;
      bus.req_a[2*W +: W] = 8'hCE;
      bus.req_b[2*W +: W] = 8'hFD;
      bus.req = 4'b0101;
      wait_ack();
      chk("p0101_ack0", 32'(bus.ack), 32'(oh(0)));
      bus.req[0] = 1'b0;
      wait_done(c);
      chk("p0101_res0", {bus.done, bus.res}, {4'b0001, 16'hFFF9});
      wait_ack();
      chk("p0101_ack2", 32'(bus.ack), 32'(oh(2)));
      bus.req[2] = 1'b0;
      wait_done(c);
      chk("p0101_res2", {bus.done, bus.res}, {4'b0100, 16'h0096});
      tick(2);

      serve("t1", 0, 8'd55, 8'd75, 16'd4125, 1'b0, lat);
      chk("t1_latency", 32'(lat), 32'd5);
      serve("t2", 1, 8'd12, 8'hF9, 16'hFFAC, 1'b0, lat);

      never_valid = 1'b1;
      serve("tmo", 3, 8'd10, 8'd10, 16'd0, 1'b1, lat);
      chk("tmo_latency", 32'(lat), 32'(TIMEOUT + 1));
      never_valid = 1'b0;
      serve("after_tmo", 1, 8'hFF, 8'hFF, 16'd1, 1'b0, lat);

      // Reset while waiting on the multiplier.
      never_valid = 1'b1;
      bus.req_a[1*W +: W] = 8'd9;
      bus.req_b[1*W +: W] = 8'd9;
      bus.req[1] = 1'b1;
      wait_ack();
      bus.req[1] = 1'b0;
      tick(2);
      chk("abort_busy_pre", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      tick(1);
      chk("abort_outputs", {bus.ack, bus.done, bus.res, bus.err, bus.busy, bus.mul_start}, 32'd0);
      chk("abort_mul_ops", {bus.mul_a, bus.mul_b}, 32'd0);
      d0 = n_done;
      rst = 1'b1;
      never_valid = 1'b0;
      tick(10);
      chk("abort_no_done", 32'(n_done), 32'(d0));
      serve("post_rst", 2, 8'd20, 8'hFB, 16'hFF9C, 1'b0, lat);

      // A valid during ISSUE carries a garbage product and must be ignored.
      bus.req_a[0*W +: W] = 8'h80;
      bus.req_b[0*W +: W] = 8'h80;
      bus.req[0] = 1'b1;
      wait_ack();
      chk("issue_ack", {bus.ack, 3'd0, bus.mul_start}, {4'b0001, 4'b0001});
      force_valid = 1'b1;
      bus.req[0] = 1'b0;
      tick(1);
      force_valid = 1'b0;
      chk("issue_still_busy", {bus.busy, bus.done}, {1'b1, 4'b0000});
      wait_done(c);
      chk("issue_done", 32'(bus.done), 32'(oh(0)));
      chk("issue_res", 32'(bus.res), 32'd16384);
      chk("issue_err", 32'(bus.err), 32'd0);
      tick(2);

      chk("total_starts", 32'(n_start), 32'd13);
      chk("total_acks", 32'(n_ack), 32'd13);
      chk("total_dones", 32'(n_done), 32'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
